// File: rtl/spi_master.sv
// Byte-oriented SPI master (modes 0-3, 8-bit divider) behind a small APB register file.
// TX writes stall on APB while a transfer is running; RX holds the last received byte.
module spi_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [1:0] RegCsr = 2'd0;
    localparam logic [1:0] RegDiv = 2'd1;
    localparam logic [1:0] RegTx  = 2'd2;
    localparam logic [1:0] RegRx  = 2'd3;

    state_e      state;
    logic        cs;
    logic        cpol;
    logic        cpha;
    logic        rxvalid;
    logic        done;
    logic [7:0]  div;
    logic [7:0]  rx;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [7:0]  half;
    logic [7:0]  hcnt;
    logic [3:0]  ecnt;

    logic        access;
    logic [1:0]  reg_sel;
    logic        busy;
    logic        tx_wr;
    logic        wr_en;
    logic        rd_en;
    logic        sck_edge;
    logic        leading;
    logic        last_edge;
    logic        sample;
    logic        present;
    logic [7:0]  rx_next;
    logic        unused_bits;

    assign access   = apbs_psel & apbs_penable;
    assign reg_sel  = apbs_paddr[3:2];
    assign busy     = (state == StShift);
    assign tx_wr    = access & apbs_pwrite & (reg_sel == RegTx);
    // Stall also in the cycle BUSY first reads 0, so a queued write lands one cycle later.
    assign apbs_pready  = ~(tx_wr & (busy | done));
    assign apbs_pslverr = 1'b0;
    assign wr_en    = access & apbs_pwrite & apbs_pready;
    assign rd_en    = access & ~apbs_pwrite;

    assign sck_edge  = busy && (hcnt == half - 8'd1);
    assign leading   = ~ecnt[0];
    assign last_edge = (ecnt == 4'd15);
    assign sample    = sck_edge & (cpha ? ~leading : leading);
    assign present   = sck_edge & ~sample;
    assign rx_next   = {rx_sh[6:0], spi_miso};

    assign spi_cs_n    = ~cs;
    assign unused_bits = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:8]};

    always_comb begin
        apbs_prdata = 32'd0;
        if (rd_en) begin
            unique case (reg_sel)
                RegCsr:  apbs_prdata = {22'd0, rxvalid, busy, 5'd0, cpha, cpol, cs};
                RegDiv:  apbs_prdata = {24'd0, div};
                RegRx:   apbs_prdata = {24'd0, rx};
                default: apbs_prdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cs       <= 1'b0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            rxvalid  <= 1'b0;
            done     <= 1'b0;
            div      <= 8'd0;
            rx       <= 8'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            half     <= 8'd1;
            hcnt     <= 8'd0;
            ecnt     <= 4'd0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rd_en && reg_sel == RegRx) begin
                rxvalid <= 1'b0;
            end
            if (wr_en && reg_sel == RegCsr) begin
                cs <= apbs_pwdata[0];
                if (!busy) begin
                    cpol <= apbs_pwdata[1];
                    cpha <= apbs_pwdata[2];
                end
            end
            if (wr_en && reg_sel == RegDiv) begin
                div <= apbs_pwdata[7:0];
            end

            case (state)
                StIdle: begin
                    // Forward a CPOL write so the idle clock level follows in the next cycle.
                    spi_sck <= (wr_en && reg_sel == RegCsr) ? apbs_pwdata[1] : cpol;
                    if (wr_en && reg_sel == RegTx) begin
                        state <= StShift;
                        tx_sh <= apbs_pwdata[7:0];
                        rx_sh <= 8'd0;
                        hcnt  <= 8'd0;
                        ecnt  <= 4'd0;
                        half  <= (div == 8'd0) ? 8'd1 : div;
                        if (!cpha) begin
                            spi_mosi <= apbs_pwdata[7];
                        end
                    end
                end
                StShift: begin
                    if (sck_edge) begin
                        hcnt    <= 8'd0;
                        ecnt    <= ecnt + 4'd1;
                        spi_sck <= ~spi_sck;
                        if (sample) begin
                            rx_sh <= rx_next;
                        end
                        if (present) begin
                            if (cpha) begin
                                spi_mosi <= tx_sh[7];
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                            end else if (!last_edge) begin
                                // bit7 went out on entry, so the trailing edge shows the next one
                                spi_mosi <= tx_sh[6];
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                            end
                        end
                        if (last_edge) begin
                            state   <= StIdle;
                            spi_sck <= cpol;
                            rx      <= cpha ? rx_next : rx_sh;
                            rxvalid <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
